// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and constants for the unified-memory port arbiter.
//   state_t : sequencing FSM states (IDLE, ISSUE, WAIT, RESP)
//   REQ_IF  : requester id of the instruction-fetch path
//   REQ_D   : requester id of the load/store path
//   BE_FULL : byte-enable pattern for a full-word read
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//
// Combinational winner selection between the IF and D requesters. All
// arbitration policy lives here so the sequencing FSM stays policy-free.
//
// Build option:
//   ARB_RR_EN defined   : on simultaneous requests the requester that did
//                         not win last time is chosen.
//   ARB_RR_EN undefined : fixed priority, D always beats IF.
//
// Ports:
//   if_req      in   IF request
//   d_req       in   D request
//   last_winner in   id of the previous winner (only used with ARB_RR_EN)
//   any_req     out  at least one request is pending
//   winner      out  id of the selected requester (REQ_IF / REQ_D)
// ---------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_winner,
    output logic any_req,
    output logic winner
);

    // Pick a winner; a lone requester always wins, contention is resolved
    // by the configured policy.
    always_comb begin
        any_req = if_req | d_req;
`ifdef ARB_RR_EN
        if (if_req && d_req) begin
            winner = ~last_winner;
        end else if (d_req) begin
            winner = REQ_D;
        end else begin
            winner = REQ_IF;
        end
`else
        winner = d_req ? REQ_D : REQ_IF;
`endif
    end

`ifndef ARB_RR_EN
    // Fixed priority has no history; the input exists only to keep the
    // port list identical in both builds.
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the CPU
// instruction-fetch path (IF) and the load/store path (D). Each access is
// sequenced as arbitrate (IDLE) -> issue (ISSUE) -> fixed read latency
// (WAIT) -> registered response (RESP). Writes finish in ISSUE.
//
// Build option: ARB_RR_EN selects alternating priority on contention
// (see arb_pick); undefined gives fixed D-over-IF priority.
//
// Parameters:
//   ADDR_W  word-address width
//   DATA_W  data width (DATA_W/8 byte enables)
//   MEM_LAT cycles from mem_en to valid mem_rdata, 1..7
//
// Ports:
//   clock, reset                       rising-edge clock, sync active-high reset
//   if_req/if_addr                     IF read request and word address
//   if_gnt/if_rvalid/if_rdata          IF grant pulse, response pulse, data
//   d_req/d_we/d_be/d_addr/d_wdata     D request, write flag, byte enables,
//                                      address, write data
//   d_gnt/d_rvalid/d_rdata             D grant pulse, read response, data
//   mem_en/mem_we/mem_be/mem_addr/
//   mem_wdata/mem_rdata                memory array interface
//   busy                               high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                id_q, id_d;
    logic                we_q, we_d;
    logic                if_gnt_q, if_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic                any_req;
    logic                winner;
    logic                last_winner;

`ifdef ARB_RR_EN
    logic                last_winner_q, last_winner_d;
    assign last_winner = last_winner_q;
`else
    assign last_winner = REQ_IF;
`endif

    arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_winner (last_winner),
        .any_req     (any_req),
        .winner      (winner)
    );

    // Next-state logic. Every output is a flop, so the values seen during
    // a state are computed on the transition into it: the memory command
    // and the grant are prepared in IDLE and appear in ISSUE, the read
    // data and rvalid are prepared in the last WAIT cycle and appear in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        we_d        = we_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_RR_EN
        last_winner_d = last_winner_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    id_d    = winner;
`ifdef ARB_RR_EN
                    last_winner_d = winner;
`endif
                    if (winner == REQ_D) begin
                        we_d        = d_we;
                        d_gnt_d     = 1'b1;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_we;
                        mem_be_d    = d_we ? d_be : BE_FULL;
                        // A write with no lanes enabled is granted but
                        // never touches the array.
                        mem_en_d    = !d_we || (d_be != '0);
                    end else begin
                        we_d       = 1'b0;
                        if_gnt_d   = 1'b1;
                        mem_addr_d = if_addr;
                        mem_be_d   = BE_FULL;
                        mem_en_d   = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(MEM_LAT);
                end
            end

            WAIT: begin
                // The counter reaches zero on this cycle's decrement, which
                // is the cycle mem_rdata is valid, so capture it now.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    if (id_q == REQ_D) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset wins over everything and drops any
    // transaction in flight without a grant or response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= REQ_IF;
            we_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_winner_q <= REQ_IF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            we_q        <= we_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances: "a" with MEM_LAT = 1 and "b" with MEM_LAT = 3, each
// attached to a small memory model whose read pipeline returns a cycle-tagged
// marker word whenever no read was issued, so a response sampled at the
// wrong cycle carries the wrong data. Expected grant/response events are
// queued when a request is driven and popped by a monitor on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int EV_IF_GNT = 0;
    localparam int EV_IF_RV  = 1;
    localparam int EV_D_GNT  = 2;
    localparam int EV_D_RV   = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
    } exp_t;

    exp_t expq_a[$];
    exp_t expq_b[$];

    int tests_run = 0;
    int failures  = 0;
    int cyc       = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Instance a signals
    logic        a_if_req = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
    logic [9:0]  a_if_addr = '0, a_d_addr = '0;
    logic [3:0]  a_d_be = '0;
    logic [31:0] a_d_wdata = '0;
    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
    logic [31:0] a_if_rdata, a_d_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [3:0]  a_mem_be;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    // Instance b signals
    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [9:0]  b_if_addr = '0, b_d_addr = '0;
    logic [3:0]  b_d_be = '0;
    logic [31:0] b_d_wdata = '0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
    logic [31:0] b_if_rdata, b_d_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [3:0]  b_mem_be;
    logic [9:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] b_pipe [0:2];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
        .clock(clock), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
        .clock(clock), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory model for instance a: one-cycle synchronous read, byte writes,
    // preloaded while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            mem_a[2]  <= 32'h20080007;
            mem_a[7]  <= 32'hCAFEF00D;
            mem_a[9]  <= 32'h9A9A0009;
            mem_a[30] <= 32'h11223344;
        end else if (a_mem_en && a_mem_we) begin
            for (int i = 0; i < 4; i++)
                if (a_mem_be[i]) mem_a[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
        end
        a_mem_rdata <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : (32'hBAD10000 | cyc);
    end

    // Memory model for instance b: three-stage read pipeline.
    always @(posedge clock) begin
        if (reset) mem_b[5] <= 32'h55AA55AA;
        b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : (32'hBAD30000 | cyc);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    // Monitor: every grant or response pulse must match the head of the
    // expectation queue for that instance in kind, cycle and (for
    // responses) data.
    always @(negedge clock) begin
        if (a_if_gnt)    checkEvent(0, EV_IF_GNT, 32'h0);
        if (a_if_rvalid) checkEvent(0, EV_IF_RV, a_if_rdata);
        if (a_d_gnt)     checkEvent(0, EV_D_GNT, 32'h0);
        if (a_d_rvalid)  checkEvent(0, EV_D_RV, a_d_rdata);
        if (b_if_gnt)    checkEvent(1, EV_IF_GNT, 32'h0);
        if (b_if_rvalid) checkEvent(1, EV_IF_RV, b_if_rdata);
        if (b_d_gnt)     checkEvent(1, EV_D_GNT, 32'h0);
        if (b_d_rvalid)  checkEvent(1, EV_D_RV, b_d_rdata);
    end

    task automatic checkEvent(input int inst, input int kind, input logic [31:0] data);
        exp_t e;
        logic is_rv;
        is_rv = (kind == EV_IF_RV) || (kind == EV_D_RV);
        tests_run++;
        if ((inst == 0 && expq_a.size() == 0) || (inst == 1 && expq_b.size() == 0)) begin
            failures++;
            $display("[TB] FAIL unexpected_event inst=%0d got kind=%0d cyc=%0d data=%h, expected none",
                     inst, kind, cyc, data);
        end else begin
            e = (inst == 0) ? expq_a.pop_front() : expq_b.pop_front();
            if (e.kind != kind || e.cyc != cyc || (is_rv && e.data != data)) begin
                failures++;
                $display("[TB] FAIL event inst=%0d got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h",
                         inst, kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int inst, input int c, input int kind, input logic [31:0] data);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.data = data;
        if (inst == 0) expq_a.push_back(e);
        else           expq_b.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one request on instance a while it is IDLE and queue its grant
    // (next cycle) and, for reads, its response two cycles after that.
    // Returns one cycle later, i.e. during the expected ISSUE cycle.
    task automatic applyStimulus(input logic is_d, input logic we, input logic [3:0] be,
                                 input logic [9:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic expect_rv);
        pushExp(0, cyc + 1, is_d ? EV_D_GNT : EV_IF_GNT, 32'h0);
        if (expect_rv) pushExp(0, cyc + 3, is_d ? EV_D_RV : EV_IF_RV, exp_rdata);
        if (is_d) begin
            a_d_req = 1'b1; a_d_we = we; a_d_be = be; a_d_addr = addr; a_d_wdata = wdata;
        end else begin
            a_if_req = 1'b1; a_if_addr = addr;
        end
        step(1);
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;

        // Reset state of both instances
        step(3);
        checkOutput("rst_a_busy", a_busy, 0);
        checkOutput("rst_a_mem_en", a_mem_en, 0);
        checkOutput("rst_a_mem_we", a_mem_we, 0);
        checkOutput("rst_a_mem_be", a_mem_be, 0);
        checkOutput("rst_a_mem_addr", a_mem_addr, 0);
        checkOutput("rst_a_mem_wdata", a_mem_wdata, 0);
        checkOutput("rst_a_if_rdata", a_if_rdata, 0);
        checkOutput("rst_a_d_rdata", a_d_rdata, 0);
        checkOutput("rst_b_busy", b_busy, 0);
        checkOutput("rst_b_mem_en", b_mem_en, 0);
        reset = 1'b0;

        // IF read of address 2
        applyStimulus(1'b0, 1'b0, 4'hF, 10'd2, 32'h0, 32'h20080007, 1'b1);
        checkOutput("if_rd_mem_en", a_mem_en, 1);
        checkOutput("if_rd_mem_we", a_mem_we, 0);
        checkOutput("if_rd_mem_be", a_mem_be, 4'hF);
        checkOutput("if_rd_mem_addr", a_mem_addr, 10'd2);
        checkOutput("if_rd_busy_c1", a_busy, 1);
        step(1);
        checkOutput("if_rd_busy_c2", a_busy, 1);
        checkOutput("if_rd_mem_en_wait", a_mem_en, 0);
        step(1);
        checkOutput("if_rd_busy_c3", a_busy, 1);
        step(1);
        checkOutput("if_rd_busy_c4", a_busy, 0);

        // D store-byte to address 30, then read it back
        applyStimulus(1'b1, 1'b1, 4'b0001, 10'd30, 32'h000000AB, 32'h0, 1'b0);
        checkOutput("sb_mem_en", a_mem_en, 1);
        checkOutput("sb_mem_we", a_mem_we, 1);
        checkOutput("sb_mem_be", a_mem_be, 4'b0001);
        checkOutput("sb_mem_addr", a_mem_addr, 10'd30);
        checkOutput("sb_mem_wdata", a_mem_wdata, 32'h000000AB);
        step(1);
        checkOutput("sb_idle_busy", a_busy, 0);
        checkOutput("sb_idle_mem_en", a_mem_en, 0);
        checkOutput("sb_idle_mem_addr_hold", a_mem_addr, 10'd30);
        applyStimulus(1'b1, 1'b0, 4'h0, 10'd30, 32'h0, 32'h112233AB, 1'b1);
        step(3);

        // D write with no byte enables leaves memory untouched
        applyStimulus(1'b1, 1'b1, 4'h0, 10'd7, 32'hFFFFFFFF, 32'h0, 1'b0);
        checkOutput("be0_mem_en", a_mem_en, 0);
        step(1);
        applyStimulus(1'b0, 1'b0, 4'hF, 10'd7, 32'h0, 32'hCAFEF00D, 1'b1);
        step(3);

        // Reset while in WAIT drops the read; new request granted right after
        applyStimulus(1'b0, 1'b0, 4'hF, 10'd9, 32'h0, 32'h0, 1'b0);
        step(1);
        reset = 1'b1;
        step(1);
        checkOutput("rstw_if_rvalid", a_if_rvalid, 0);
        checkOutput("rstw_busy", a_busy, 0);
        checkOutput("rstw_mem_en", a_mem_en, 0);
        checkOutput("rstw_mem_addr", a_mem_addr, 0);
        checkOutput("rstw_if_rdata", a_if_rdata, 0);
        checkOutput("rstw_d_rdata", a_d_rdata, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'hF, 10'd2, 32'h0, 32'h20080007, 1'b1);
        step(3);

        // Simultaneous requests: D first, then IF
        c = cyc;
        pushExp(0, c + 1, EV_D_GNT, 32'h0);
        pushExp(0, c + 3, EV_D_RV, 32'hCAFEF00D);
        pushExp(0, c + 5, EV_IF_GNT, 32'h0);
        pushExp(0, c + 7, EV_IF_RV, 32'h9A9A0009);
`ifdef ARB_RR_EN
        pushExp(0, c + 9, EV_D_GNT, 32'h0);
        pushExp(0, c + 11, EV_D_RV, 32'hCAFEF00D);
`endif
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 10'd7;
        a_if_req = 1'b1; a_if_addr = 10'd9;
        step(1);
        checkOutput("both_mem_addr", a_mem_addr, 10'd7);
`ifdef ARB_RR_EN
        step(8);
        a_d_req = 1'b0;
        a_if_req = 1'b0;
        step(3);
`else
        a_d_req = 1'b0;
        step(4);
        a_if_req = 1'b0;
        step(3);
`endif
        checkOutput("both_if_rdata_hold", a_if_rdata, 32'h9A9A0009);

        // MEM_LAT = 3: D read of address 5 on instance b
        c = cyc;
        pushExp(1, c + 1, EV_D_GNT, 32'h0);
        pushExp(1, c + 5, EV_D_RV, 32'h55AA55AA);
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'd5;
        step(1);
        b_d_req = 1'b0;
        checkOutput("lat3_mem_en", b_mem_en, 1);
        checkOutput("lat3_mem_addr", b_mem_addr, 10'd5);
        step(3);
        checkOutput("lat3_busy_wait", b_busy, 1);
        step(2);
        checkOutput("lat3_busy_idle", b_busy, 0);
        checkOutput("lat3_d_rdata_hold", b_d_rdata, 32'h55AA55AA);

        step(5);
        checkOutput("queue_a_drained", expq_a.size(), 0);
        checkOutput("queue_b_drained", expq_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
